// File: rtl/bk_pkg.sv
// Shared widths and FSM encoding for the Bk backtrace controller.
// Imported by the path buffer and the backtrace top.
package bk_pkg;

    localparam int SW      = 2;
    localparam int FW      = 6;
    localparam int AW      = FW + SW;
    localparam int DW      = 8;
    localparam int NSTATES = 1 << SW;
    localparam int NFRAMES = 1 << FW;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        CAPT,
        EMIT
    } bk_st_t;

endpackage

// File: rtl/bk_path_buf.sv
// Recovered state sequence storage, one entry per frame.
// Single synchronous write port, asynchronous read port, no reset.
module bk_path_buf
    import bk_pkg::*;
(
    input  logic          clk,
    input  logic          we,
    input  logic [FW-1:0] wa,
    input  logic [SW-1:0] wd,
    input  logic [FW-1:0] ra,
    output logic [SW-1:0] rd
);

    logic [SW-1:0] mem [NFRAMES];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
    end

    assign rd = mem[ra];

endmodule

// File: rtl/bk_backtrace.sv
// Viterbi backtrace: walks the Bk backpointer ROM from frame T to 0,
// then streams the recovered path out in frame-ascending order.
module bk_backtrace
    import bk_pkg::*;
(
    input  logic          CS,
    input  logic          cen,
    input  logic          start,
    input  logic [FW-1:0] start_frame,
    input  logic [SW-1:0] start_state,
    output logic          busy,
    output logic [AW-1:0] add,
    input  logic [DW-1:0] Bkp,
    output logic          path_valid,
    output logic [FW-1:0] path_frame,
    output logic [SW-1:0] path_state,
    output logic          path_last,
    input  logic          path_ready,
    output logic          err
);

    bk_st_t        state, state_n;
    logic [FW-1:0] t_r, t_n;
    logic [FW-1:0] cur_f, cur_f_n;
    logic [FW-1:0] idx, idx_n;
    logic [AW-1:0] add_n;
    logic          err_n;

    logic          we;
    logic [FW-1:0] wa;
    logic [SW-1:0] wd;
    logic [SW-1:0] rd;

    logic [FW-1:0] f_dec;
    logic [SW-1:0] p;
    logic          bad;

    assign f_dec = cur_f - FW'(1);
    assign p     = Bkp[SW-1:0];
    // Any set bit above the state field means a pointer >= NSTATES.
    assign bad   = |Bkp[DW-1:SW];

    bk_path_buf u_buf (
        .clk (CS),
        .we  (we),
        .wa  (wa),
        .wd  (wd),
        .ra  (idx),
        .rd  (rd)
    );

    always_ff @(posedge CS or negedge cen) begin
        if (!cen) begin
            state <= IDLE;
            t_r   <= '0;
            cur_f <= '0;
            idx   <= '0;
            add   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            t_r   <= t_n;
            cur_f <= cur_f_n;
            idx   <= idx_n;
            add   <= add_n;
            err   <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        t_n     = t_r;
        cur_f_n = cur_f;
        idx_n   = idx;
        add_n   = add;
        err_n   = err;
        we      = 1'b0;
        wa      = f_dec;
        wd      = p;
        unique case (state)
            IDLE: begin
                if (start) begin
                    t_n   = start_frame;
                    idx_n = '0;
                    err_n = 1'b0;
                    we    = 1'b1;
                    wa    = start_frame;
                    wd    = start_state;
                    if (start_frame == '0) begin
                        state_n = EMIT;
                    end else begin
                        add_n   = {start_frame, start_state};
                        cur_f_n = start_frame;
                        state_n = WAIT;
                    end
                end
            end
            WAIT: begin
                state_n = CAPT;
            end
            CAPT: begin
                if (bad) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    we      = 1'b1;
                    cur_f_n = f_dec;
                    if (f_dec == '0) begin
                        state_n = EMIT;
                    end else begin
                        add_n   = {f_dec, p};
                        state_n = WAIT;
                    end
                end
            end
            EMIT: begin
                if (path_ready) begin
                    if (idx == t_r) begin
                        state_n = IDLE;
                    end else begin
                        idx_n = idx + FW'(1);
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign busy       = (state != IDLE);
    assign path_valid = (state == EMIT);
    // Beat fields read as zero whenever no beat is presented.
    assign path_frame = path_valid ? idx : '0;
    assign path_state = path_valid ? rd : '0;
    assign path_last  = path_valid && (idx == t_r);

endmodule

// File: tb/tb_bk_backtrace.sv
// Self-checking bench for bk_backtrace with a registered Bk ROM model
// and a beat scoreboard.
module tb_bk_backtrace;
    import bk_pkg::*;

    logic          CS = 1'b0;
    logic          cen = 1'b0;
    logic          start = 1'b0;
    logic [FW-1:0] start_frame = '0;
    logic [SW-1:0] start_state = '0;
    logic          busy;
    logic [AW-1:0] add;
    logic [DW-1:0] Bkp;
    logic          path_valid;
    logic [FW-1:0] path_frame;
    logic [SW-1:0] path_state;
    logic          path_last;
    logic          path_ready = 1'b1;
    logic          err;

    int total = 0;
    int bad = 0;
    int beats = 0;
    bit rom_mode = 1'b0;

    typedef struct packed {
        logic [FW-1:0] f;
        logic [SW-1:0] s;
        logic          l;
    } beat_t;

    beat_t q[$];

    bk_backtrace dut (
        .CS          (CS),
        .cen         (cen),
        .start       (start),
        .start_frame (start_frame),
        .start_state (start_state),
        .busy        (busy),
        .add         (add),
        .Bkp         (Bkp),
        .path_valid  (path_valid),
        .path_frame  (path_frame),
        .path_state  (path_state),
        .path_last   (path_last),
        .path_ready  (path_ready),
        .err         (err)
    );

    always #5 CS = ~CS;

    function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
        if (rom_mode && a == AW'(9)) return 8'h05;
        if (a == '0) return 8'h00;
        return 8'h02;
    endfunction

    always @(posedge CS or negedge cen) begin
        if (!cen) Bkp <= '0;
        else Bkp <= rom(add);
    end

    // Scoreboard: every accepted beat must match the oldest expected one.
    always @(negedge CS) begin
        if (path_valid && path_ready) begin
            beat_t e;
            beats++;
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL beat_unexpected: got f=%0d s=%0d l=%0d, required none",
                         path_frame, path_state, path_last);
            end else begin
                e = q.pop_front();
                if ({path_frame, path_state, path_last} !== e) begin
                    bad++;
                    $display("FAIL beat: got f=%0d s=%0d l=%0d, required f=%0d s=%0d l=%0d",
                             path_frame, path_state, path_last, e.f, e.s, e.l);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CS);
        #1;
    endtask

    task automatic pulse_start(input logic [FW-1:0] f, input logic [SW-1:0] s);
        start_frame = f;
        start_state = s;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_std();
        q.push_back({FW'(0), SW'(2), 1'b0});
        q.push_back({FW'(1), SW'(2), 1'b0});
        q.push_back({FW'(2), SW'(2), 1'b0});
        q.push_back({FW'(3), SW'(1), 1'b1});
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((q.size() != 0 || busy) && n < 60) begin
            tick();
            n++;
        end
        total++;
        if (q.size() != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_drain: got left=%0d busy=%b, required left=0 busy=0",
                     name, q.size(), busy);
        end
        q.delete();
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({busy, add, path_valid, path_frame, path_state, path_last, err} !== '0) begin
            bad++;
            $display("FAIL reset: got busy=%b add=%0d v=%b f=%0d s=%0d l=%b err=%b, required all 0",
                     busy, add, path_valid, path_frame, path_state, path_last, err);
        end
        #12 cen = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [AW-1:0] exp_add [6] = '{13, 13, 10, 10, 6, 6};
        int cyc = 0;
        int b0 = beats;
        push_std();
        pulse_start(3, 1);
        cyc = 1;
        while (!path_valid && cyc < 20) begin
            if (cyc <= 6) begin
                total++;
                if (add !== exp_add[cyc-1]) begin
                    bad++;
                    $display("FAIL basic_add%0d: got %0d, required %0d",
                             cyc, add, exp_add[cyc-1]);
                end
            end
            tick();
            cyc++;
        end
        total++;
        if (cyc != 7) begin
            bad++;
            $display("FAIL basic_latency: got %0d, required 7", cyc);
        end
        drain("basic");
        total++;
        if (beats - b0 != 4) begin
            bad++;
            $display("FAIL basic_count: got %0d, required 4", beats - b0);
        end
    endtask

    task automatic test_zero();
        logic [AW-1:0] a0 = add;
        q.push_back({FW'(0), SW'(3), 1'b1});
        pulse_start(0, 3);
        total++;
        if (path_valid !== 1'b1 || add !== a0) begin
            bad++;
            $display("FAIL zero_first: got v=%b add=%0d, required v=1 add=%0d",
                     path_valid, add, a0);
        end
        drain("zero");
    endtask

    task automatic test_error();
        int sawv = 0;
        rom_mode = 1'b1;
        pulse_start(2, 1);
        for (int i = 0; i < 2; i++) begin
            if (path_valid) sawv++;
            tick();
        end
        total++;
        if (err !== 1'b1 || busy !== 1'b0 || sawv != 0 || path_valid !== 1'b0) begin
            bad++;
            $display("FAIL error_flag: got err=%b busy=%b valid_seen=%0d, required err=1 busy=0 valid_seen=0",
                     err, busy, sawv + int'(path_valid));
        end
        tick();
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL error_sticky: got %b, required 1", err);
        end
        rom_mode = 1'b0;
        q.push_back({FW'(0), SW'(0), 1'b1});
        pulse_start(0, 0);
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL error_clear: got %b, required 0", err);
        end
        drain("error");
    endtask

    task automatic test_backpressure();
        int n = 0;
        int b0 = beats;
        push_std();
        pulse_start(3, 1);
        while (!(path_valid && path_frame == 1) && n < 20) begin
            tick();
            n++;
        end
        path_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (path_valid !== 1'b1 || path_frame !== FW'(1) || path_state !== SW'(2)) begin
                bad++;
                $display("FAIL bp_hold%0d: got v=%b f=%0d s=%0d, required v=1 f=1 s=2",
                         i, path_valid, path_frame, path_state);
            end
        end
        path_ready = 1'b1;
        drain("bp");
        total++;
        if (beats - b0 != 4) begin
            bad++;
            $display("FAIL bp_count: got %0d, required 4", beats - b0);
        end
    endtask

    task automatic test_start_busy();
        int b0 = beats;
        push_std();
        pulse_start(3, 1);
        tick();
        pulse_start(5, 0);
        for (int i = 0; i < 4; i++) tick();
        pulse_start(5, 0);
        drain("busy_start");
        total++;
        if (beats - b0 != 4 || err !== 1'b0) begin
            bad++;
            $display("FAIL busy_start_count: got beats=%0d err=%b, required beats=4 err=0",
                     beats - b0, err);
        end
    endtask

    task automatic test_reset_mid();
        pulse_start(3, 1);
        tick();
        tick();
        cen = 1'b0;
        #1;
        total++;
        if ({busy, add, path_valid, path_frame, path_state, path_last, err} !== '0) begin
            bad++;
            $display("FAIL midreset: got busy=%b add=%0d v=%b f=%0d s=%0d l=%b err=%b, required all 0",
                     busy, add, path_valid, path_frame, path_state, path_last, err);
        end
        #7 cen = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        total++;
        if (busy !== 1'b0 || path_valid !== 1'b0) begin
            bad++;
            $display("FAIL midreset_idle: got busy=%b v=%b, required 0 0", busy, path_valid);
        end
        push_std();
        pulse_start(3, 1);
        drain("midreset_restart");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_error();
        test_backpressure();
        test_start_busy();
        test_reset_mid();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
